// File: rtl/debug_controller.sv
// Run/halt/single-step sequencer and host register-file access arbiter for the 8-bit core.
// Optional PC breakpoint is compiled in when DBG_BREAKPOINT_EN is defined.
module debug_controller #(
    parameter int DATA_W       = 8,
    parameter int RF_ADR_W     = 4,
    parameter int PC_W         = 5,
    parameter bit RESET_HALTED = 1'b0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dbg_halt_req,
    input  logic                dbg_step_req,
    input  logic                dbg_resume_req,
    input  logic                dbg_rd_req,
    input  logic                dbg_wr_req,
    input  logic [RF_ADR_W-1:0] dbg_adr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    output logic [DATA_W-1:0]   dbg_rdata,
    output logic                dbg_ack,
    output logic                dbg_halted,
    output logic [1:0]          halt_cause,
`ifdef DBG_BREAKPOINT_EN
    input  logic                dbg_bp_wr,
    input  logic [PC_W-1:0]     dbg_bp_adr,
    input  logic                dbg_bp_en,
`endif
    input  logic                core_halt_in,
    input  logic [PC_W-1:0]     core_pc,
    output logic                core_run,
    output logic                rf_sel,
    output logic [RF_ADR_W-1:0] rf_adr,
    output logic                rf_we,
    output logic [DATA_W-1:0]   rf_wdata,
    input  logic [DATA_W-1:0]   rf_rdata
);

    typedef enum logic [2:0] {
        ST_RUN    = 3'd0,
        ST_STEP   = 3'd1,
        ST_HALTED = 3'd2,
        ST_ACCESS = 3'd3,
        ST_ACK    = 3'd4
    } state_t;

    localparam state_t     RST_STATE = RESET_HALTED ? ST_HALTED : ST_RUN;
    localparam logic [1:0] RST_CAUSE = RESET_HALTED ? 2'b01 : 2'b00;

    state_t              r_state;
    logic [1:0]          r_cause;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ack;
    logic                r_rf_sel;
    logic                r_rf_we;
    logic [RF_ADR_W-1:0] r_rf_adr;
    logic [DATA_W-1:0]   r_rf_wdata;
    logic                r_is_wr;
    logic                w_bp_hit;
    logic                w_resume_go;

    // Resume is only honoured in HALTED when no higher-priority request is present
    assign w_resume_go = (r_state == ST_HALTED) && dbg_resume_req &&
                         !dbg_wr_req && !dbg_rd_req && !dbg_step_req;

`ifdef DBG_BREAKPOINT_EN
    logic [PC_W-1:0] r_bp_adr;
    logic            r_bp_en;
    logic            r_bp_skip;

    // Breakpoint registers; skip masks the hit during the first RUN cycle after resume
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bp_adr  <= {PC_W{1'b0}};
            r_bp_en   <= 1'b0;
            r_bp_skip <= 1'b0;
        end else begin
            if (dbg_bp_wr) begin
                r_bp_adr <= dbg_bp_adr;
                r_bp_en  <= dbg_bp_en;
            end
            if (w_resume_go) begin
                r_bp_skip <= 1'b1;
            end else if (r_state == ST_RUN) begin
                r_bp_skip <= 1'b0;
            end
        end
    end

    assign w_bp_hit = (r_state == ST_RUN) && r_bp_en && !r_bp_skip && (core_pc == r_bp_adr);
`else
    logic w_unused_pc;
    assign w_unused_pc = ^core_pc;
    assign w_bp_hit    = 1'b0;
`endif

    // Main sequencer: run/step/halt control and the two-cycle register access
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= RST_STATE;
            r_cause    <= RST_CAUSE;
            r_rdata    <= {DATA_W{1'b0}};
            r_ack      <= 1'b0;
            r_rf_sel   <= 1'b0;
            r_rf_we    <= 1'b0;
            r_rf_adr   <= {RF_ADR_W{1'b0}};
            r_rf_wdata <= {DATA_W{1'b0}};
            r_is_wr    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (dbg_halt_req) begin
                        r_state <= ST_HALTED;
                        r_cause <= 2'b01;
                    end else if (core_halt_in) begin
                        r_state <= ST_HALTED;
                        r_cause <= 2'b10;
                    end else if (w_bp_hit) begin
                        r_state <= ST_HALTED;
                        r_cause <= 2'b11;
                    end else begin
                        r_state <= ST_RUN;
                    end
                end
                ST_STEP: begin
                    r_state <= ST_HALTED;
                    if (core_halt_in) begin
                        r_cause <= 2'b10;
                    end else begin
                        r_cause <= r_cause;
                    end
                end
                ST_HALTED: begin
                    if (dbg_wr_req || dbg_rd_req) begin
                        r_state    <= ST_ACCESS;
                        r_is_wr    <= dbg_wr_req;
                        r_rf_sel   <= 1'b1;
                        r_rf_we    <= dbg_wr_req;
                        r_rf_adr   <= dbg_adr;
                        if (dbg_wr_req) begin
                            r_rf_wdata <= dbg_wdata;
                        end
                    end else if (dbg_step_req) begin
                        r_state <= ST_STEP;
                    end else if (dbg_resume_req) begin
                        r_state <= ST_RUN;
                        r_cause <= 2'b00;
                    end else begin
                        r_state <= ST_HALTED;
                    end
                end
                ST_ACCESS: begin
                    if (!r_is_wr) begin
                        r_rdata <= rf_rdata;
                    end
                    r_state  <= ST_ACK;
                    r_ack    <= 1'b1;
                    r_rf_sel <= 1'b0;
                    r_rf_we  <= 1'b0;
                end
                ST_ACK: begin
                    r_state <= ST_HALTED;
                    r_ack   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_HALTED;
                    r_ack    <= 1'b0;
                    r_rf_sel <= 1'b0;
                    r_rf_we  <= 1'b0;
                end
            endcase
        end
    end

    assign core_run   = (r_state == ST_STEP) || ((r_state == ST_RUN) && !w_bp_hit);
    assign dbg_halted = (r_state == ST_HALTED) || (r_state == ST_ACCESS) || (r_state == ST_ACK);
    assign halt_cause = r_cause;
    assign dbg_rdata  = r_rdata;
    assign dbg_ack    = r_ack;
    assign rf_sel     = r_rf_sel;
    assign rf_we      = r_rf_we;
    assign rf_adr     = r_rf_adr;
    assign rf_wdata   = r_rf_wdata;

endmodule

// File: tb/tb_debug_controller.sv
// Directed, table-driven bench for debug_controller with a tiny core/register-file model.
module tb_debug_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       dbg_halt_req = 1'b0, dbg_step_req = 1'b0, dbg_resume_req = 1'b0;
    logic       dbg_rd_req = 1'b0, dbg_wr_req = 1'b0;
    logic [3:0] dbg_adr = 4'h0;
    logic [7:0] dbg_wdata = 8'h00;
    logic [7:0] dbg_rdata;
    logic       dbg_ack, dbg_halted;
    logic [1:0] halt_cause;
    logic       core_halt_in = 1'b0;
    logic [4:0] pc = 5'd0;
    logic       core_run, rf_sel, rf_we;
    logic [3:0] rf_adr;
    logic [7:0] rf_wdata, rf_rdata;
`ifdef DBG_BREAKPOINT_EN
    logic       dbg_bp_wr = 1'b0;
    logic [4:0] dbg_bp_adr = 5'd0;
    logic       dbg_bp_en = 1'b0;
`endif

    logic [7:0] rf [16] = '{8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
                            8'h88, 8'h99, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF};
    int run_cnt = 0;
    int ack_cnt = 0;
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    debug_controller #(.DATA_W(8), .RF_ADR_W(4), .PC_W(5), .RESET_HALTED(1'b0)) u_dut (
        .clk(clk), .rst(rst),
        .dbg_halt_req(dbg_halt_req), .dbg_step_req(dbg_step_req),
        .dbg_resume_req(dbg_resume_req), .dbg_rd_req(dbg_rd_req), .dbg_wr_req(dbg_wr_req),
        .dbg_adr(dbg_adr), .dbg_wdata(dbg_wdata), .dbg_rdata(dbg_rdata),
        .dbg_ack(dbg_ack), .dbg_halted(dbg_halted), .halt_cause(halt_cause),
`ifdef DBG_BREAKPOINT_EN
        .dbg_bp_wr(dbg_bp_wr), .dbg_bp_adr(dbg_bp_adr), .dbg_bp_en(dbg_bp_en),
`endif
        .core_halt_in(core_halt_in), .core_pc(pc), .core_run(core_run),
        .rf_sel(rf_sel), .rf_adr(rf_adr), .rf_we(rf_we), .rf_wdata(rf_wdata),
        .rf_rdata(rf_rdata)
    );

    // Core model: PC advances on each enabled cycle; register file written through the debug port
    assign rf_rdata = rf[rf_adr];
    always @(posedge clk or posedge rst) begin
        if (rst) pc <= 5'd0;
        else if (core_run) pc <= pc + 5'd1;
    end
    always @(posedge clk) begin
        if (core_run && !rst) run_cnt <= run_cnt + 1;
        if (dbg_ack) ack_cnt <= ack_cnt + 1;
        if (rf_sel && rf_we) rf[rf_adr] <= rf_wdata;
    end

    // ctl = {halt, step, resume, rd, wr, core_halt}; exp = {core_run, halted, ack, rf_sel, rf_we}
    typedef struct {
        logic [5:0] ctl;
        logic [3:0] adr;
        logic [7:0] wdata;
        logic [4:0] exp;
        logic [1:0] cause;
        logic [7:0] rdata;
    } vec_t;
    vec_t vecs [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input logic [5:0] ctl, input logic [3:0] adr, input logic [7:0] wd);
        @(negedge clk);
        {dbg_halt_req, dbg_step_req, dbg_resume_req, dbg_rd_req, dbg_wr_req, core_halt_in} = ctl;
        dbg_adr   = adr;
        dbg_wdata = wd;
        @(posedge clk);
        #1;
        {dbg_halt_req, dbg_step_req, dbg_resume_req, dbg_rd_req, dbg_wr_req, core_halt_in} = 6'b0;
    endtask

    initial begin
        int pc0;
        int rc0;
        int ac0;
        vecs[0]  = '{6'b000000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'h00};
        vecs[1]  = '{6'b000100, 4'h3, 8'h00, 5'b10000, 2'd0, 8'h00};
        vecs[2]  = '{6'b000000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'h00};
        vecs[3]  = '{6'b100000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'h00};
        vecs[4]  = '{6'b100000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'h00};
        vecs[5]  = '{6'b000010, 4'h3, 8'hA5, 5'b01011, 2'd1, 8'h00};
        vecs[6]  = '{6'b000000, 4'h0, 8'h00, 5'b01100, 2'd1, 8'h00};
        vecs[7]  = '{6'b000000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'h00};
        vecs[8]  = '{6'b000100, 4'h3, 8'h00, 5'b01010, 2'd1, 8'h00};
        vecs[9]  = '{6'b000000, 4'h0, 8'h00, 5'b01100, 2'd1, 8'hA5};
        vecs[10] = '{6'b000000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'hA5};
        vecs[11] = '{6'b010000, 4'h0, 8'h00, 5'b10000, 2'd1, 8'hA5};
        vecs[12] = '{6'b001000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'hA5};
        vecs[13] = '{6'b010010, 4'h5, 8'h3C, 5'b01011, 2'd1, 8'hA5};
        vecs[14] = '{6'b010000, 4'h0, 8'h00, 5'b01100, 2'd1, 8'hA5};
        vecs[15] = '{6'b000000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'hA5};
        vecs[16] = '{6'b001000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'hA5};
        vecs[17] = '{6'b000001, 4'h0, 8'h00, 5'b01000, 2'd2, 8'hA5};
        vecs[18] = '{6'b001001, 4'h0, 8'h00, 5'b10000, 2'd0, 8'hA5};
        vecs[19] = '{6'b000001, 4'h0, 8'h00, 5'b01000, 2'd2, 8'hA5};
        vecs[20] = '{6'b001000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'hA5};
        vecs[21] = '{6'b100001, 4'h0, 8'h00, 5'b01000, 2'd1, 8'hA5};
        vecs[22] = '{6'b000100, 4'h5, 8'h00, 5'b01010, 2'd1, 8'hA5};
        vecs[23] = '{6'b000000, 4'h0, 8'h00, 5'b01100, 2'd1, 8'h3C};
        vecs[24] = '{6'b000000, 4'h0, 8'h00, 5'b01000, 2'd1, 8'h3C};
        vecs[25] = '{6'b010001, 4'h0, 8'h00, 5'b10000, 2'd1, 8'h3C};
        vecs[26] = '{6'b000001, 4'h0, 8'h00, 5'b01000, 2'd2, 8'h3C};
        vecs[27] = '{6'b011100, 4'h3, 8'h00, 5'b01010, 2'd2, 8'h3C};
        vecs[28] = '{6'b000000, 4'h0, 8'h00, 5'b01100, 2'd2, 8'hA5};
        vecs[29] = '{6'b000000, 4'h0, 8'h00, 5'b01000, 2'd2, 8'hA5};
        vecs[30] = '{6'b001000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'hA5};
        vecs[31] = '{6'b000000, 4'h0, 8'h00, 5'b10000, 2'd0, 8'hA5};

        // Reset state
        #2;
        chk("rst_core_run", 32'(core_run), 32'd1);
        chk("rst_halted", 32'(dbg_halted), 32'd0);
        chk("rst_cause", 32'(halt_cause), 32'd0);
        chk("rst_ack", 32'(dbg_ack), 32'd0);
        chk("rst_rf_sel", 32'(rf_sel), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_rf_adr", 32'(rf_adr), 32'd0);
        chk("rst_rf_wdata", 32'(rf_wdata), 32'd0);
        chk("rst_rdata", 32'(dbg_rdata), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) begin
            cyc(vecs[i].ctl, vecs[i].adr, vecs[i].wdata);
            chk($sformatf("v%0d_core_run", i), 32'(core_run), 32'(vecs[i].exp[4]));
            chk($sformatf("v%0d_halted", i), 32'(dbg_halted), 32'(vecs[i].exp[3]));
            chk($sformatf("v%0d_ack", i), 32'(dbg_ack), 32'(vecs[i].exp[2]));
            chk($sformatf("v%0d_rf_sel", i), 32'(rf_sel), 32'(vecs[i].exp[1]));
            chk($sformatf("v%0d_rf_we", i), 32'(rf_we), 32'(vecs[i].exp[0]));
            chk($sformatf("v%0d_cause", i), 32'(halt_cause), 32'(vecs[i].cause));
            chk($sformatf("v%0d_rdata", i), 32'(dbg_rdata), 32'(vecs[i].rdata));
        end
        chk("rf3_written", 32'(rf[3]), 32'hA5);
        chk("rf5_written", 32'(rf[5]), 32'h3C);
        chk("rf4_untouched", 32'(rf[4]), 32'h44);

        // Single-step: three pulses four cycles apart execute exactly three instructions
        cyc(6'b100000, 4'h0, 8'h00);
        cyc(6'b000000, 4'h0, 8'h00);
        pc0 = int'(pc);
        rc0 = run_cnt;
        for (int s = 0; s < 3; s++) begin
            cyc(6'b010000, 4'h0, 8'h00);
            chk($sformatf("step%0d_run", s), 32'(core_run), 32'd1);
            cyc(6'b000000, 4'h0, 8'h00);
            chk($sformatf("step%0d_halted", s), 32'(dbg_halted), 32'd1);
            cyc(6'b000000, 4'h0, 8'h00);
            cyc(6'b000000, 4'h0, 8'h00);
        end
        chk("step_run_cycles", 32'(run_cnt - rc0), 32'd3);
        chk("step_pc_advance", 32'((int'(pc) - pc0 + 32) % 32), 32'd3);

        // Reset during a write access to R1 aborts it
        ac0 = ack_cnt;
        cyc(6'b000010, 4'h1, 8'h77);
        chk("abort_in_access_we", 32'(rf_we), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_we_cleared", 32'(rf_we), 32'd0);
        chk("abort_sel_cleared", 32'(rf_sel), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) cyc(6'b000000, 4'h0, 8'h00);
        chk("abort_no_ack", 32'(ack_cnt - ac0), 32'd0);
        chk("abort_rf1_unchanged", 32'(rf[1]), 32'h11);
        chk("abort_back_in_run", 32'(core_run), 32'd1);

`ifdef DBG_BREAKPOINT_EN
        begin
            int waited;
            cyc(6'b100000, 4'h0, 8'h00);
            @(negedge clk);
            dbg_bp_wr = 1'b1; dbg_bp_adr = 5'd7; dbg_bp_en = 1'b1;
            @(negedge clk);
            dbg_bp_wr = 1'b0;
            cyc(6'b001000, 4'h0, 8'h00);
            waited = 0;
            while (!dbg_halted && waited < 80) begin
                cyc(6'b000000, 4'h0, 8'h00);
                waited++;
            end
            chk("bp_halt_within_budget", 32'(dbg_halted), 32'd1);
            chk("bp_cause", 32'(halt_cause), 32'd3);
            chk("bp_pc", 32'(pc), 32'd7);
            chk("bp_run_off", 32'(core_run), 32'd0);
            cyc(6'b001000, 4'h0, 8'h00);
            chk("bp_skip_run", 32'(core_run), 32'd1);
            cyc(6'b000000, 4'h0, 8'h00);
            chk("bp_pc7_executed", 32'(pc), 32'd8);
            chk("bp_no_rehit", 32'(dbg_halted), 32'd0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/debug_controller.md
# debug_controller

Run/halt/single-step sequencer and register-file access arbiter for the 8-bit processor. It sits between a host debug port and the processor core. It gates instruction execution through a run enable. While the core is frozen it takes over the register-file port so the host can read or write registers. It halts the core on host request, on a program `HALT`, or (optionally) on a PC breakpoint.

## Interface
- `DATA_W`, 8, register data width
- `RF_ADR_W`, 4, register-file address width
- `PC_W`, 5, program-counter width
- `RESET_HALTED`, 0, 1 = leave reset in HALTED, 0 = leave reset in RUN
- `clk` in 1: system clock; all state changes on rising edge
- `rst` in 1: reset, asynchronous, active-high
- `dbg_halt_req` in 1: single-cycle pulse, request halt
- `dbg_step_req` in 1: single-cycle pulse, execute one instruction
- `dbg_resume_req` in 1: single-cycle pulse, return to free run
- `dbg_rd_req` in 1: single-cycle pulse, register read
- `dbg_wr_req` in 1: single-cycle pulse, register write
- `dbg_adr` in RF_ADR_W: register address for read/write
- `dbg_wdata` in DATA_W: register write data
- `dbg_rdata` out DATA_W: read data, valid while `dbg_ack`=1
- `dbg_ack` out 1: one-cycle completion pulse for rd/wr
- `dbg_halted` out 1: core frozen (HALTED, ACCESS or ACK)
- `halt_cause` out 2: 00 none, 01 host, 10 program, 11 breakpoint
- `core_halt_in` in 1: core's own halt indication
- `core_pc` in PC_W: current program counter
- `core_run` out 1: core execute enable (PC, acc, ext, cb and RF writes qualified by it)
- `rf_sel` out 1: 1 = register-file port driven by this block
- `rf_adr` out RF_ADR_W, `rf_we` out 1, `rf_wdata` out DATA_W: register-file port when `rf_sel`=1
- `rf_rdata` in DATA_W: register-file read data

## Operation
- FSM states: RUN, STEP, HALTED, ACCESS, ACK.
- `core_run` = 1 in RUN and STEP, else 0. It is combinational from state and the breakpoint hit.
- RUN:
  - `dbg_halt_req` → HALTED, cause 01.
  - else `core_halt_in`=1 → HALTED, cause 10.
  - Host halt wins a simultaneous event.
- HALTED: requests are sampled with priority wr > rd > step > resume.
  - wr/rd → ACCESS.
  - step → STEP.
  - resume → RUN, cause 00.
  - `dbg_halt_req` is ignored.
- STEP: one cycle with `core_run`=1, then unconditionally → HALTED. Cause is preserved, or set to 10 if `core_halt_in`=1.
- ACCESS:
  - `rf_sel`=1, `rf_adr`=`dbg_adr` latched at acceptance.
  - Write: `rf_we`=1, `rf_wdata`=latched `dbg_wdata`.
  - Read: `rf_rdata` captured into `dbg_rdata` at the end of the cycle.
  - Then → ACK.
- ACK: `dbg_ack`=1 for one cycle, `rf_sel`=0, → HALTED.
- rd/wr/step/resume pulses in RUN, STEP, ACCESS or ACK are dropped (no ack).
- Resume while `core_halt_in` remains 1 re-enters HALTED (cause 10) the next cycle.
- `dbg_rdata` holds its last value outside ACK.
- `rf_we`=0 and `rf_sel`=0 in every state other than ACCESS.

## Timing
- Reset values:
  - state = HALTED if `RESET_HALTED` else RUN.
  - `halt_cause` = 01 if `RESET_HALTED` else 00.
  - `dbg_rdata`=0, `dbg_ack`=0, `rf_sel`=0, `rf_we`=0, `rf_adr`=0, `rf_wdata`=0.
  - Breakpoint disabled.
- Halt latency: pulse sampled at edge N; `core_run`=0 from cycle N+1. The instruction in cycle N completes.
- Register access latency: request at edge N → ACCESS in cycle N+1 → `dbg_ack` in cycle N+2. Next request is accepted from N+3.
- Step: request at edge N → exactly one instruction executes in cycle N+1 → halted in N+2.
- Reset asserted mid-ACCESS aborts the access: no ack, no write.

## Configuration
- `DBG_BREAKPOINT_EN` defined adds:
  - Inputs `dbg_bp_wr` (1), `dbg_bp_adr` (PC_W), `dbg_bp_en` (1).
  - `dbg_bp_wr` loads the breakpoint address/enable in any state, effective next cycle.
- In RUN, `core_pc`==bp address with enable=1 forces `core_run`=0 combinationally (the instruction at that PC does not execute) and enters HALTED with cause 11.
- A skip flag suppresses the hit for the first RUN cycle after resume. STEP ignores breakpoints.
- `DBG_BREAKPOINT_EN` undefined: ports absent, cause 11 never produced.

## Test plan
- Reset with `RESET_HALTED`=0, pulse `dbg_halt_req` at cycle 5 → `core_run`=0 from cycle 6, `dbg_halted`=1, `halt_cause`=01.
- While halted, write 0xA5 to R3, then read R3 → two `dbg_ack` pulses, each 2 cycles after its request; read returns `dbg_rdata`=0xA5; `rf_we` high exactly one cycle.
- Halted, three `dbg_step_req` pulses 4 cycles apart → exactly three cycles with `core_run`=1, PC advances by 3.
- Raise `core_halt_in` in RUN → HALTED, cause 10. Resume while it is still 1 → back in HALTED next cycle.
- With `DBG_BREAKPOINT_EN`, bp=0x07 → halts with PC=7, cause 11, instruction 7 not executed. Resume → PC 7 executes, no re-hit.
- `dbg_rd_req` pulsed in RUN → no ack; assert `rst` during ACCESS of a write to R1 → R1 unchanged, no ack.
